timer_sequencer: RTL and testbench
==================================

Name: timer_sequencer

Overview:
- Sequencing controller for the HH:MM:SS countdown-alarm datapath.
- Latches the programmed target time and runs a packed-BCD up-counter from 00:00:00 on a 1 Hz tick.
- Drives the enable of the external time comparator and reacts to its registered fin flag.
- Raises the alarm, handles pause/resume/clear, and returns to idle on acknowledge or timeout.

Parameters:
- ALARM_TICKS, 10: number of tick pulses the alarm stays high in DONE before auto-return to IDLE; 0 disables the timeout.
- HOUR_MAX, 8'h23: highest legal BCD hour value; hours wrap to 00 above it.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- tick  in  1  1 Hz single-cycle pulse; consecutive pulses at least 3 clocks apart
- load  in  1  capture prog_h/m/s (honoured in IDLE only)
- prog_h, prog_m, prog_s  in  8 each  programmed target time, packed BCD
- start  in  1  start from IDLE, or resume from PAUSE
- stop  in  1  pause while RUN
- clear  in  1  abort to IDLE from any state
- ack  in  1  alarm acknowledge
- cmp_fin  in  1  comparator match flag, registered, 1-cycle latency
- tgt_h, tgt_m, tgt_s  out  8 each  latched target, wired to comparator prog inputs
- cnt_h, cnt_m, cnt_s  out  8 each  running count, wired to comparator count inputs
- cmp_en  out  1  comparator enable
- alarm  out  1  alarm active
- running  out  1  high in RUN
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
- load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
Reset:
- state=IDLE; tgt_*, cnt_* = 8'h00; cmp_en=0; alarm=0; running=0; load_err=0; alarm tick counter=0.

Load and validation:
- In IDLE, load with valid BCD (seconds and minutes 00-59, hours 00-HOUR_MAX, each nibble ≤ 9) registers prog into tgt on the next edge.
- An invalid load leaves tgt unchanged and pulses load_err for 1 cycle.
- load outside IDLE is ignored, with no load_err.

IDLE:
- cmp_en=0; cnt held at 00:00:00.
- start with tgt≠00:00:00 → RUN, counter cleared.
- start with tgt=00:00:00 → ignored; state stays IDLE.

RUN:
- cmp_en=1; running=1.
- Per-cycle priority: clear > cmp_fin > stop > tick.
  - clear → IDLE, cnt cleared.
  - cmp_fin → DONE.
  - stop → PAUSE; a coincident tick is discarded.
  - tick → increment count.
- Increment rules:
  - Seconds BCD: 09→10, 59→00 with carry to minutes.
  - Minutes: 59→00 with carry to hours.
  - Hours: HOUR_MAX→00, so 23:59:59 → 00:00:00.
  - Each count register updates 1 cycle after the tick.

PAUSE:
- cmp_en=0, which clears the comparator fin; cnt held.
- start → RUN with count preserved.
- clear → IDLE with cnt cleared.
- tick ignored.

DONE:
- alarm=1; cmp_en=1; cnt frozen; tick increments the alarm counter only.
- ack or clear → IDLE next cycle; alarm=0; cnt cleared.
- Alarm counter reaching ALARM_TICKS (ALARM_TICKS≠0) → IDLE, same as ack.

Latency:
- Tick making cnt==tgt at edge N+1 → cmp_fin at edge N+2 → state=DONE and alarm=1 at edge N+3.

Outputs and reset:
- All outputs are registered.
- reset low mid-operation forces the reset values immediately, independent of clock.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE/RUN/PAUSE/DONE);
  - BCD limit constants (8'h59, default HOUR_MAX);
  - a BCD-validity function for one 8-bit field.
- Sub-module bcd_hms_counter: BCD seconds/minutes/hours counter with clear, inc, HOUR_MAX parameter, and wrap. It is also reused by the display path.

Test Plan:
- Load 00:00:03, start, 3 ticks with the comparator connected → cnt 00:00:03, cmp_fin, DONE with alarm=1 exactly 2 clocks after the 3rd tick's count update.
- Load 00:00:00 then start → state stays IDLE, cmp_en=0. Load 00:00:5A → load_err pulse, tgt unchanged.
- Preload target 01:00:00, run with count at 00:59:59, one tick → 01:00:00. Count at 23:59:59 (HOUR_MAX 23), one tick → 00:00:00.
- RUN at 00:00:01, stop and tick in the same cycle → PAUSE with cnt 00:00:01 unchanged. Extra ticks → cnt unchanged. start → RUN; next tick → 00:00:02.
- In DONE with ALARM_TICKS=2, two ticks → IDLE, alarm=0. Repeat and assert ack after 0 ticks → IDLE next cycle.
- Assert reset low asynchronously mid-RUN (between clock edges) → all outputs at reset values before the next edge. clear together with cmp_fin → IDLE, not DONE.

Source files
------------

// File: rtl/timer_sequencer_pkg.sv
// Shared types, BCD limits and helpers for the HH:MM:SS alarm sequencer.
package timer_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] BCD_MAX_MS     = 8'h59;
  localparam logic [7:0] BCD_MAX_H_DFLT = 8'h23;

  // Packed-BCD ordering matches binary ordering for valid digits.
  function automatic logic bcd_field_ok(input logic [7:0] v, input logic [7:0] max_v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
  endfunction

  function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/timer_sequencer_if.sv
// Control/status bundle between the sequencer and its environment.
interface timer_sequencer_if;
  import timer_sequencer_pkg::*;

  logic       i_tick;
  logic       i_load;
  logic [7:0] i_prog_h, i_prog_m, i_prog_s;
  logic       i_start, i_stop, i_clear, i_ack;
  logic       i_cmp_fin;
  logic [7:0] o_tgt_h, o_tgt_m, o_tgt_s;
  logic [7:0] o_cnt_h, o_cnt_m, o_cnt_s;
  logic       o_cmp_en, o_alarm, o_running, o_load_err;
  state_t     o_state;

  modport master (
    output i_tick, i_load, i_prog_h, i_prog_m, i_prog_s,
           i_start, i_stop, i_clear, i_ack, i_cmp_fin,
    input  o_tgt_h, o_tgt_m, o_tgt_s, o_cnt_h, o_cnt_m, o_cnt_s,
           o_cmp_en, o_alarm, o_running, o_load_err, o_state
  );

  modport slave (
    input  i_tick, i_load, i_prog_h, i_prog_m, i_prog_s,
           i_start, i_stop, i_clear, i_ack, i_cmp_fin,
    output o_tgt_h, o_tgt_m, o_tgt_s, o_cnt_h, o_cnt_m, o_cnt_s,
           o_cmp_en, o_alarm, o_running, o_load_err, o_state
  );

endinterface

// File: rtl/timer_sequencer_bcd_hms_counter.sv
// Packed-BCD HH:MM:SS up-counter with clear, preload and wrap at HOUR_MAX:59:59.
// Registered outputs; clear beats load beats increment.
module timer_sequencer_bcd_hms_counter
  import timer_sequencer_pkg::*;
#(
  parameter logic [7:0] HOUR_MAX = BCD_MAX_H_DFLT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_ld,
  input  logic [7:0] i_ld_h,
  input  logic [7:0] i_ld_m,
  input  logic [7:0] i_ld_s,
  input  logic       i_inc,
  output logic [7:0] o_h,
  output logic [7:0] o_m,
  output logic [7:0] o_s
);

  logic [7:0] r_h, r_m, r_s;
  logic       w_s_wrap, w_m_wrap, w_h_wrap;

  assign w_s_wrap = (r_s == BCD_MAX_MS);
  assign w_m_wrap = (r_m == BCD_MAX_MS);
  assign w_h_wrap = (r_h == HOUR_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h <= 8'h00;
      r_m <= 8'h00;
      r_s <= 8'h00;
    end else if (i_clr) begin
      r_h <= 8'h00;
      r_m <= 8'h00;
      r_s <= 8'h00;
    end else if (i_ld) begin
      r_h <= i_ld_h;
      r_m <= i_ld_m;
      r_s <= i_ld_s;
    end else if (i_inc) begin
      r_s <= w_s_wrap ? 8'h00 : bcd_inc8(r_s);
      if (w_s_wrap) begin
        r_m <= w_m_wrap ? 8'h00 : bcd_inc8(r_m);
        if (w_m_wrap) begin
          r_h <= w_h_wrap ? 8'h00 : bcd_inc8(r_h);
        end
      end
    end
  end

  assign o_h = r_h;
  assign o_m = r_m;
  assign o_s = r_s;

endmodule

// File: rtl/timer_sequencer.sv
// Alarm sequencer: latches target, runs BCD count on tick, enables comparator, raises alarm.
// All outputs registered; fin-to-DONE is one edge after the comparator registers the match.
module timer_sequencer
  import timer_sequencer_pkg::*;
#(
  parameter int unsigned ALARM_TICKS = 10,
  parameter logic [7:0]  HOUR_MAX    = BCD_MAX_H_DFLT
) (
  input logic               i_clk,
  input logic               i_rst_n,
  timer_sequencer_if.slave  sq_if
);

  localparam logic [15:0] ALM_LIM = ALARM_TICKS[15:0];

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_tgt_h, r_tgt_m, r_tgt_s;
  logic        r_cmp_en, r_alarm, r_running, r_load_err;
  logic [15:0] r_alm_cnt;
  logic        w_load_ok, w_tgt_zero, w_alm_hit;
  logic        w_inc, w_tgt_ld, w_load_err_nxt, w_alm_inc, w_cnt_clr;
  logic [7:0]  w_cnt_h, w_cnt_m, w_cnt_s;

  assign w_load_ok  = bcd_field_ok(sq_if.i_prog_s, BCD_MAX_MS) &&
                      bcd_field_ok(sq_if.i_prog_m, BCD_MAX_MS) &&
                      bcd_field_ok(sq_if.i_prog_h, HOUR_MAX);
  assign w_tgt_zero = ({r_tgt_h, r_tgt_m, r_tgt_s} == 24'h000000);
  assign w_alm_hit  = (ALARM_TICKS != 0) && ((r_alm_cnt + 16'd1) == ALM_LIM);

  always_comb begin
    w_state_nxt    = r_state;
    w_inc          = 1'b0;
    w_tgt_ld       = 1'b0;
    w_load_err_nxt = 1'b0;
    w_alm_inc      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sq_if.i_load) begin
          w_tgt_ld       = w_load_ok;
          w_load_err_nxt = !w_load_ok;
        end
        if (!sq_if.i_clear && sq_if.i_start && !w_tgt_zero) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (sq_if.i_clear)        w_state_nxt = ST_IDLE;
        else if (sq_if.i_cmp_fin) w_state_nxt = ST_DONE;
        else if (sq_if.i_stop)    w_state_nxt = ST_PAUSE;
        else if (sq_if.i_tick)    w_inc = 1'b1;
      end
      ST_PAUSE: begin
        if (sq_if.i_clear)      w_state_nxt = ST_IDLE;
        else if (sq_if.i_start) w_state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (sq_if.i_ack || sq_if.i_clear) w_state_nxt = ST_IDLE;
        else if (sq_if.i_tick) begin
          if (w_alm_hit) w_state_nxt = ST_IDLE;
          else           w_alm_inc = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The count only ever lives outside IDLE, so any IDLE-bound edge clears it.
  assign w_cnt_clr = (w_state_nxt == ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_tgt_h    <= 8'h00;
      r_tgt_m    <= 8'h00;
      r_tgt_s    <= 8'h00;
      r_cmp_en   <= 1'b0;
      r_alarm    <= 1'b0;
      r_running  <= 1'b0;
      r_load_err <= 1'b0;
      r_alm_cnt  <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cmp_en   <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DONE);
      r_alarm    <= (w_state_nxt == ST_DONE);
      r_running  <= (w_state_nxt == ST_RUN);
      r_load_err <= w_load_err_nxt;
      r_alm_cnt  <= (w_state_nxt != ST_DONE) ? 16'd0 :
                    (w_alm_inc ? r_alm_cnt + 16'd1 : r_alm_cnt);
      if (w_tgt_ld) begin
        r_tgt_h <= sq_if.i_prog_h;
        r_tgt_m <= sq_if.i_prog_m;
        r_tgt_s <= sq_if.i_prog_s;
      end
    end
  end

  timer_sequencer_bcd_hms_counter #(.HOUR_MAX(HOUR_MAX)) u_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_cnt_clr),
    .i_ld    (1'b0),
    .i_ld_h  (8'h00),
    .i_ld_m  (8'h00),
    .i_ld_s  (8'h00),
    .i_inc   (w_inc),
    .o_h     (w_cnt_h),
    .o_m     (w_cnt_m),
    .o_s     (w_cnt_s)
  );

  assign sq_if.o_state    = r_state;
  assign sq_if.o_tgt_h    = r_tgt_h;
  assign sq_if.o_tgt_m    = r_tgt_m;
  assign sq_if.o_tgt_s    = r_tgt_s;
  assign sq_if.o_cnt_h    = w_cnt_h;
  assign sq_if.o_cnt_m    = w_cnt_m;
  assign sq_if.o_cnt_s    = w_cnt_s;
  assign sq_if.o_cmp_en   = r_cmp_en;
  assign sq_if.o_alarm    = r_alarm;
  assign sq_if.o_running  = r_running;
  assign sq_if.o_load_err = r_load_err;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer with a registered comparator model and a standalone counter.
module tb_timer_sequencer;
  import timer_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  timer_sequencer_if bus ();

  timer_sequencer #(.ALARM_TICKS(2), .HOUR_MAX(8'h23)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .sq_if   (bus.slave)
  );

  // Registered comparator: fin follows (enabled && count == target) by one edge.
  logic r_fin;
  logic cmp_sel = 1'b0;
  logic fin_force = 1'b0;
  wire [23:0] w_tgt = {bus.o_tgt_h, bus.o_tgt_m, bus.o_tgt_s};
  wire [23:0] w_cnt = {bus.o_cnt_h, bus.o_cnt_m, bus.o_cnt_s};
  wire [3:0]  w_flg = {bus.o_cmp_en, bus.o_alarm, bus.o_running, bus.o_load_err};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fin <= 1'b0;
    else        r_fin <= bus.o_cmp_en && (w_tgt == w_cnt);
  end
  assign bus.i_cmp_fin = cmp_sel ? fin_force : r_fin;

  // Standalone counter instance so the hour wrap can be reached by preload.
  logic       c_clr = 1'b0, c_ld = 1'b0, c_inc = 1'b0;
  logic [7:0] c_ld_h = 8'h00, c_ld_m = 8'h00, c_ld_s = 8'h00;
  logic [7:0] c_h, c_m, c_s;

  timer_sequencer_bcd_hms_counter #(.HOUR_MAX(8'h23)) u_cnt (
    .i_clk (clk), .i_rst_n (rst_n), .i_clr (c_clr), .i_ld (c_ld),
    .i_ld_h (c_ld_h), .i_ld_m (c_ld_m), .i_ld_s (c_ld_s), .i_inc (c_inc),
    .o_h (c_h), .o_m (c_m), .o_s (c_s)
  );

  task step; @(posedge clk); #1; endtask
  task pulse_tick; bus.i_tick = 1'b1; step; bus.i_tick = 1'b0; endtask
  task do_load(input logic [23:0] t);
    {bus.i_prog_h, bus.i_prog_m, bus.i_prog_s} = t;
    bus.i_load = 1'b1; step; bus.i_load = 1'b0;
  endtask
  task do_start; bus.i_start = 1'b1; step; bus.i_start = 1'b0; endtask
  task do_ack;   bus.i_ack   = 1'b1; step; bus.i_ack   = 1'b0; endtask
  task do_clear; bus.i_clear = 1'b1; step; bus.i_clear = 1'b0; endtask
  task c_load(input logic [23:0] t);
    {c_ld_h, c_ld_m, c_ld_s} = t; c_ld = 1'b1; step; c_ld = 1'b0;
  endtask

  task test_reset;
    rst_n = 1'b0;
    {bus.i_tick, bus.i_load, bus.i_start, bus.i_stop, bus.i_clear, bus.i_ack} = '0;
    {bus.i_prog_h, bus.i_prog_m, bus.i_prog_s} = '0;
    #12;
    n_chk++; if (bus.o_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want 0", bus.o_state); end
    n_chk++; if (w_tgt !== 24'h0) begin n_err++; $display("FAIL reset_tgt: got %h want 000000", w_tgt); end
    n_chk++; if (w_cnt !== 24'h0) begin n_err++; $display("FAIL reset_cnt: got %h want 000000", w_cnt); end
    n_chk++; if (w_flg !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", w_flg); end
    @(negedge clk); rst_n = 1'b1; step;
  endtask

  task test_basic;
    do_load(24'h000003);
    n_chk++; if (w_tgt !== 24'h000003 || w_flg !== 4'b0000) begin n_err++; $display("FAIL basic_load: tgt %h flags %b want 000003/0000", w_tgt, w_flg); end
    do_start;
    n_chk++; if (bus.o_state !== ST_RUN || w_flg !== 4'b1010 || w_cnt !== 24'h0) begin n_err++; $display("FAIL basic_start: state %0d flags %b cnt %h want 1/1010/000000", bus.o_state, w_flg, w_cnt); end
    for (int i = 1; i <= 3; i++) begin
      pulse_tick;
      n_chk++; if (w_cnt !== 24'(i)) begin n_err++; $display("FAIL basic_cnt: got %h want %h", w_cnt, 24'(i)); end
      if (i < 3) begin step; step; end
    end
    n_chk++; if (bus.o_state !== ST_RUN) begin n_err++; $display("FAIL basic_still_run: got %0d want 1", bus.o_state); end
    step;
    n_chk++; if (bus.i_cmp_fin !== 1'b1 || bus.o_state !== ST_RUN) begin n_err++; $display("FAIL basic_fin: fin %b state %0d want 1/1", bus.i_cmp_fin, bus.o_state); end
    step;
    n_chk++; if (bus.o_state !== ST_DONE || w_flg !== 4'b1100 || w_cnt !== 24'h000003) begin n_err++; $display("FAIL basic_done: state %0d flags %b cnt %h want 3/1100/000003", bus.o_state, w_flg, w_cnt); end
    do_ack;
    n_chk++; if (bus.o_state !== ST_IDLE || w_flg !== 4'b0000 || w_cnt !== 24'h0) begin n_err++; $display("FAIL basic_ack: state %0d flags %b cnt %h want 0/0000/000000", bus.o_state, w_flg, w_cnt); end
  endtask

  task test_load_reject;
    do_load(24'h000000);
    n_chk++; if (w_tgt !== 24'h0 || w_flg !== 4'b0000) begin n_err++; $display("FAIL zero_load: tgt %h flags %b want 000000/0000", w_tgt, w_flg); end
    do_start;
    n_chk++; if (bus.o_state !== ST_IDLE || w_flg !== 4'b0000) begin n_err++; $display("FAIL zero_start: state %0d flags %b want 0/0000", bus.o_state, w_flg); end
    do_load(24'h00005A);
    n_chk++; if (w_flg !== 4'b0001 || w_tgt !== 24'h0) begin n_err++; $display("FAIL bad_sec: flags %b tgt %h want 0001/000000", w_flg, w_tgt); end
    step;
    n_chk++; if (w_flg !== 4'b0000) begin n_err++; $display("FAIL err_pulse_len: flags %b want 0000", w_flg); end
    do_load(24'h006000);
    n_chk++; if (w_flg !== 4'b0001 || w_tgt !== 24'h0) begin n_err++; $display("FAIL bad_min: flags %b tgt %h want 0001/000000", w_flg, w_tgt); end
    do_load(24'h240000);
    n_chk++; if (w_flg !== 4'b0001 || w_tgt !== 24'h0) begin n_err++; $display("FAIL bad_hour: flags %b tgt %h want 0001/000000", w_flg, w_tgt); end
    do_load(24'h235959);
    n_chk++; if (w_flg !== 4'b0000 || w_tgt !== 24'h235959) begin n_err++; $display("FAIL max_load: flags %b tgt %h want 0000/235959", w_flg, w_tgt); end
  endtask

  task test_pause;
    do_load(24'h000005); do_start; pulse_tick; step; step;
    bus.i_stop = 1'b1; bus.i_tick = 1'b1; step; bus.i_stop = 1'b0; bus.i_tick = 1'b0;
    n_chk++; if (bus.o_state !== ST_PAUSE || w_cnt !== 24'h000001 || w_flg !== 4'b0000) begin n_err++; $display("FAIL pause_enter: state %0d cnt %h flags %b want 2/000001/0000", bus.o_state, w_cnt, w_flg); end
    step; step; pulse_tick; step; step; pulse_tick;
    n_chk++; if (bus.o_state !== ST_PAUSE || w_cnt !== 24'h000001) begin n_err++; $display("FAIL pause_hold: state %0d cnt %h want 2/000001", bus.o_state, w_cnt); end
    do_start;
    n_chk++; if (bus.o_state !== ST_RUN || w_cnt !== 24'h000001 || w_flg !== 4'b1010) begin n_err++; $display("FAIL resume: state %0d cnt %h flags %b want 1/000001/1010", bus.o_state, w_cnt, w_flg); end
    step; step; pulse_tick;
    n_chk++; if (w_cnt !== 24'h000002) begin n_err++; $display("FAIL resume_tick: got %h want 000002", w_cnt); end
    do_clear;
    n_chk++; if (bus.o_state !== ST_IDLE || w_cnt !== 24'h0) begin n_err++; $display("FAIL run_clear: state %0d cnt %h want 0/000000", bus.o_state, w_cnt); end
  endtask

  task test_timeout;
    do_load(24'h000001); do_start; pulse_tick; step; step;
    n_chk++; if (bus.o_state !== ST_DONE) begin n_err++; $display("FAIL to_done: got %0d want 3", bus.o_state); end
    step; pulse_tick;
    n_chk++; if (bus.o_state !== ST_DONE || bus.o_alarm !== 1'b1) begin n_err++; $display("FAIL to_first_tick: state %0d alarm %b want 3/1", bus.o_state, bus.o_alarm); end
    step; step; pulse_tick;
    n_chk++; if (bus.o_state !== ST_IDLE || w_flg !== 4'b0000 || w_cnt !== 24'h0) begin n_err++; $display("FAIL to_expire: state %0d flags %b cnt %h want 0/0000/000000", bus.o_state, w_flg, w_cnt); end
    do_start; pulse_tick; step; step;
    n_chk++; if (bus.o_state !== ST_DONE) begin n_err++; $display("FAIL to_redone: got %0d want 3", bus.o_state); end
    do_ack;
    n_chk++; if (bus.o_state !== ST_IDLE || bus.o_alarm !== 1'b0) begin n_err++; $display("FAIL ack_zero_ticks: state %0d alarm %b want 0/0", bus.o_state, bus.o_alarm); end
  endtask

  task test_clear_fin;
    do_load(24'h000007); do_start;
    cmp_sel = 1'b1; fin_force = 1'b1; bus.i_clear = 1'b1; step; bus.i_clear = 1'b0; fin_force = 1'b0;
    n_chk++; if (bus.o_state !== ST_IDLE || w_flg !== 4'b0000) begin n_err++; $display("FAIL clear_vs_fin: state %0d flags %b want 0/0000", bus.o_state, w_flg); end
    do_start;
    fin_force = 1'b1; bus.i_stop = 1'b1; step; bus.i_stop = 1'b0; fin_force = 1'b0;
    n_chk++; if (bus.o_state !== ST_DONE) begin n_err++; $display("FAIL fin_vs_stop: got %0d want 3", bus.o_state); end
    do_clear; cmp_sel = 1'b0;
    n_chk++; if (bus.o_state !== ST_IDLE || w_flg !== 4'b0000) begin n_err++; $display("FAIL done_clear: state %0d flags %b want 0/0000", bus.o_state, w_flg); end
  endtask

  task test_carry;
    do_load(24'h010000); do_start;
    do_load(24'h000001);
    n_chk++; if (w_tgt !== 24'h010000 || w_flg !== 4'b1010) begin n_err++; $display("FAIL load_in_run: tgt %h flags %b want 010000/1010", w_tgt, w_flg); end
    for (int i = 1; i <= 3600; i++) begin
      pulse_tick;
      if (i == 60) begin
        n_chk++; if (w_cnt !== 24'h000100) begin n_err++; $display("FAIL min_carry: got %h want 000100", w_cnt); end
      end
      if (i == 3599) begin
        n_chk++; if (w_cnt !== 24'h005959 || bus.o_state !== ST_RUN) begin n_err++; $display("FAIL pre_hour: cnt %h state %0d want 005959/1", w_cnt, bus.o_state); end
      end
      if (i == 3600) begin
        n_chk++; if (w_cnt !== 24'h010000) begin n_err++; $display("FAIL hour_carry: got %h want 010000", w_cnt); end
      end
      step; step;
    end
    n_chk++; if (bus.o_state !== ST_DONE || bus.o_alarm !== 1'b1) begin n_err++; $display("FAIL hour_done: state %0d alarm %b want 3/1", bus.o_state, bus.o_alarm); end
    do_clear;
  endtask

  task test_wrap;
    c_load(24'h235959); c_inc = 1'b1; step; c_inc = 1'b0;
    n_chk++; if ({c_h, c_m, c_s} !== 24'h000000) begin n_err++; $display("FAIL day_wrap: got %h want 000000", {c_h, c_m, c_s}); end
    c_load(24'h095959); c_inc = 1'b1; step; c_inc = 1'b0;
    n_chk++; if ({c_h, c_m, c_s} !== 24'h100000) begin n_err++; $display("FAIL hour_digit: got %h want 100000", {c_h, c_m, c_s}); end
    c_load(24'h000009); c_inc = 1'b1; step; c_inc = 1'b0;
    n_chk++; if ({c_h, c_m, c_s} !== 24'h000010) begin n_err++; $display("FAIL sec_digit: got %h want 000010", {c_h, c_m, c_s}); end
    c_load(24'h001959); c_inc = 1'b1; step; c_inc = 1'b0;
    n_chk++; if ({c_h, c_m, c_s} !== 24'h002000) begin n_err++; $display("FAIL min_digit: got %h want 002000", {c_h, c_m, c_s}); end
    c_clr = 1'b1; step; c_clr = 1'b0;
    n_chk++; if ({c_h, c_m, c_s} !== 24'h000000) begin n_err++; $display("FAIL cnt_clear: got %h want 000000", {c_h, c_m, c_s}); end
  endtask

  task test_async_reset;
    do_load(24'h000002); do_start; pulse_tick;
    #3 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.o_state !== ST_IDLE || w_flg !== 4'b0000) begin n_err++; $display("FAIL arst_ctl: state %0d flags %b want 0/0000", bus.o_state, w_flg); end
    n_chk++; if (w_cnt !== 24'h0 || w_tgt !== 24'h0) begin n_err++; $display("FAIL arst_data: cnt %h tgt %h want 000000/000000", w_cnt, w_tgt); end
    #2 rst_n = 1'b1;
    step;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_load_reject;
    test_pause;
    test_timeout;
    test_clear_fin;
    test_carry;
    test_wrap;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
